// File: rtl/sparc_mem_responder_pkg.sv
// Shared codes for the SPARC memory responder: access types, R/W polarity, FSM states.
package sparc_mem_responder_pkg;

    typedef enum logic [1:0] {
        TYPE_BYTE = 2'b00,
        TYPE_HALF = 2'b01,
        TYPE_WORD = 2'b10,
        TYPE_RSVD = 2'b11
    } mem_type_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    // Reserved type is rejected too, so any non-legal access reports Err.
    function automatic logic access_rejected(mem_type_e t, logic [1:0] a);
        case (t)
            TYPE_BYTE: access_rejected = 1'b0;
            TYPE_HALF: access_rejected = a[0];
            TYPE_WORD: access_rejected = |a;
            default:   access_rejected = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sparc_mem_array.sv
// Byte-wide memory with a 4-lane big-endian port; lane k addresses byte addr+k (bits 31-8k..24-8k).
module sparc_mem_array #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [0:DEPTH-1];

    // Upper lanes may wrap past the top for narrow accesses; those lanes are never consumed.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < 4; k++)
            rdata[31-8*k -: 8] = mem[addr + ADDR_W'(k)];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[addr + ADDR_W'(k)] <= wdata[31-8*k -: 8];
        end
    end

endmodule

// File: rtl/sparc_mem_responder.sv
// SPARC main memory answering the CU's MOV/MOC handshake after a fixed number of wait states.
module sparc_mem_responder
    import sparc_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        Type,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Err
);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_type_e         type_q, type_d;
    logic              rw_q, rw_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       dout_q, dout_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;

    logic              arr_we;
    logic [3:0]        arr_be;
    logic [31:0]       arr_wdata;
    logic [31:0]       arr_rdata;
    logic              rejected;

    sparc_mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (Clk),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (addr_q),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign rejected = access_rejected(type_q, addr_q[1:0]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        type_d    = type_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        moc_d     = moc_q;
        err_d     = err_q;
        arr_we    = 1'b0;
        arr_be    = 4'b0000;
        arr_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (MOV) begin
                    addr_d  = Address;
                    type_d  = mem_type_e'(Type);
                    rw_d    = RW;
                    wdata_d = DataIn;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            // The accept-settle cycle plus WAIT_STATES counted edges keeps MOC
            // landing WAIT_STATES+2 edges after the accept edge.
            ST_WAIT: begin
                if (cnt_q == WAIT_CNT) state_d = ST_ACCESS;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                moc_d   = 1'b1;
                err_d   = rejected;
                if (rejected) begin
                    dout_d = '0;
                end else if (rw_q == RW_READ) begin
                    case (type_q)
                        TYPE_BYTE: dout_d = {24'b0, arr_rdata[31:24]};
                        TYPE_HALF: dout_d = {16'b0, arr_rdata[31:16]};
                        default:   dout_d = arr_rdata;
                    endcase
                end else begin
                    arr_we = 1'b1;
                    case (type_q)
                        TYPE_BYTE: begin
                            arr_be    = 4'b0001;
                            arr_wdata = {wdata_q[7:0], 24'b0};
                        end
                        TYPE_HALF: begin
                            arr_be    = 4'b0011;
                            arr_wdata = {wdata_q[15:0], 16'b0};
                        end
                        default: begin
                            arr_be    = 4'b1111;
                            arr_wdata = wdata_q;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                if (!MOV) begin
                    state_d = ST_IDLE;
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
        end
        addr_q  <= addr_d;
        type_q  <= type_d;
        rw_q    <= rw_d;
        wdata_q <= wdata_d;
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_sparc_mem_responder.sv
// Directed bench for sparc_mem_responder with WAIT_STATES=2.
module tb_sparc_mem_responder;

    logic        Clk = 1'b0;
    logic        Clr, MOV, RW;
    logic [1:0]  Type;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC, Err;

    int nchecks = 0;
    int nerr    = 0;

    sparc_mem_responder #(.ADDR_W(9), .WAIT_STATES(2)) dut (
        .Clk(Clk), .Clr(Clr), .MOV(MOV), .RW(RW), .Type(Type),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
        .MOC(MOC), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full handshake: raise MOV, wait for MOC (bounded), check, drop MOV, check MOC falls.
    task automatic access(input logic rw, input logic [1:0] ty, input logic [8:0] a,
                          input logic [31:0] d, input logic [31:0] exp_dout,
                          input logic exp_err, input string tag);
        int n;
        MOV = 1'b1; RW = rw; Type = ty; Address = a; DataIn = d;
        n = 0;
        do begin
            @(posedge Clk); #1; n++;
        end while (!MOC && n < 40);
        chk({tag, " latency"}, 32'(n - 1), 32'd4);
        chk({tag, " err"}, {31'b0, Err}, {31'b0, exp_err});
        chk({tag, " dout"}, DataOut, exp_dout);
        MOV = 1'b0; Address = ~a; DataIn = ~d;
        @(posedge Clk); #1;
        chk({tag, " moc_fall"}, {31'b0, MOC}, 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        Clr = 1'b1; MOV = 1'b0; RW = 1'b1; Type = 2'b00; Address = '0; DataIn = '0;
        repeat (2) @(posedge Clk);
        #1 Clr = 1'b0;
        chk("reset moc", {31'b0, MOC}, 32'd0);
        chk("reset err", {31'b0, Err}, 32'd0);
        chk("reset dout", DataOut, 32'd0);

        // Word write/read and byte extraction
        access(1'b0, 2'b10, 9'd8,  32'hDEADBEEF, 32'h0,        1'b0, "wr word 8");
        access(1'b1, 2'b10, 9'd8,  32'h0,        32'hDEADBEEF, 1'b0, "rd word 8");
        access(1'b1, 2'b00, 9'd9,  32'h0,        32'h000000AD, 1'b0, "rd byte 9");

        // Narrow writes assemble a word; upper DataIn bits must be ignored
        access(1'b0, 2'b01, 9'd20, 32'hAAAA1234, 32'h000000AD, 1'b0, "wr half 20");
        access(1'b0, 2'b00, 9'd22, 32'hFFFFFF56, 32'h000000AD, 1'b0, "wr byte 22");
        access(1'b0, 2'b00, 9'd23, 32'h00000078, 32'h000000AD, 1'b0, "wr byte 23");
        access(1'b1, 2'b10, 9'd20, 32'h0,        32'h12345678, 1'b0, "rd word 20");

        // Rejected accesses leave memory alone
        dut.u_array.mem[4] = 8'h11; dut.u_array.mem[5] = 8'h22;
        dut.u_array.mem[6] = 8'h33; dut.u_array.mem[7] = 8'h44;
        access(1'b1, 2'b10, 9'd6,  32'h0,        32'h0,        1'b1, "rd word 6 misaligned");
        access(1'b0, 2'b10, 9'd6,  32'hFFFFFFFF, 32'h0,        1'b1, "wr word 6 misaligned");
        access(1'b0, 2'b11, 9'd4,  32'hFFFFFFFF, 32'h0,        1'b1, "wr rsvd 4");
        access(1'b1, 2'b01, 9'd5,  32'h0,        32'h0,        1'b1, "rd half 5 misaligned");
        access(1'b1, 2'b11, 9'd0,  32'h0,        32'h0,        1'b1, "rd rsvd 0");
        access(1'b1, 2'b10, 9'd4,  32'h0,        32'h11223344, 1'b0, "rd word 4 unchanged");

        // Handshake hold: MOC and DataOut stay put while MOV is held
        MOV = 1'b1; RW = 1'b1; Type = 2'b10; Address = 9'd8;
        n = 0;
        do begin @(posedge Clk); #1; n++; end while (!MOC && n < 40);
        chk("hold latency", 32'(n - 1), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            chk("hold moc", {31'b0, MOC}, 32'd1);
            chk("hold dout", DataOut, 32'hDEADBEEF);
        end
        MOV = 1'b0;
        @(posedge Clk); #1;
        chk("hold moc_fall", {31'b0, MOC}, 32'd0);
        access(1'b1, 2'b10, 9'd20, 32'h0, 32'h12345678, 1'b0, "rd after hold");

        // Clr during WAIT aborts the write
        dut.u_array.mem[40] = 8'hA1; dut.u_array.mem[41] = 8'hB2;
        dut.u_array.mem[42] = 8'hC3; dut.u_array.mem[43] = 8'hD4;
        MOV = 1'b1; RW = 1'b0; Type = 2'b10; Address = 9'd40; DataIn = 32'hCAFEF00D;
        @(posedge Clk); #1;
        Clr = 1'b1; MOV = 1'b0;
        @(posedge Clk); #1;
        Clr = 1'b0;
        chk("abort moc", {31'b0, MOC}, 32'd0);
        chk("abort err", {31'b0, Err}, 32'd0);
        chk("abort dout", DataOut, 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            if (MOC) pulses++;
        end
        chk("abort no moc", 32'(pulses), 32'd0);
        access(1'b1, 2'b10, 9'd40, 32'h0, 32'hA1B2C3D4, 1'b0, "rd word 40 after abort");

        // MOV dropped during WAIT: access completes, MOC pulses once
        MOV = 1'b1; RW = 1'b1; Type = 2'b00; Address = 9'd41;
        @(posedge Clk); #1;
        MOV = 1'b0; Address = 9'd0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (MOC) pulses++;
        end
        chk("drop-in-wait moc cycles", 32'(pulses), 32'd1);
        chk("drop-in-wait dout", DataOut, 32'h000000B2);

        // Preload/dump loop
        for (int i = 0; i <= 60; i++) dut.u_array.mem[i] = 8'(i);
        for (int i = 0; i <= 60; i++)
            access(1'b1, 2'b00, 9'(i), 32'h0, 32'(i), 1'b0, $sformatf("dump %0d", i));

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
